fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the width of one beat read from the FIFO read port.
REQ-002 The module SHALL have parameter PACK, default 4, giving beats per output word; the value SHALL be a power of 2, 1..16.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port r_valid, input, 1: FIFO read side has a beat available.
REQ-006 Port r_data, input, DATA_WIDTH: FIFO head beat, valid whenever r_valid=1.
REQ-007 Port r_ready, output, 1: beat accepted this cycle when r_valid && r_ready.
REQ-008 Port flush, input, 1: single-cycle request to emit a partially filled word.
REQ-009 Port out_valid, output, 1: out_data/out_keep hold a word.
REQ-010 Port out_ready, input, 1: downstream takes the word when out_valid && out_ready.
REQ-011 Port out_data, output, DATA_WIDTH*PACK: packed word.
REQ-012 Port out_keep, output, PACK: one bit per lane, 1 = lane holds a received beat.
REQ-013 Port busy, output, 1: accumulator non-empty, flush pending, or out_valid.
REQ-014 Port seq_err, output, 1: sticky sequence-check error flag.

Function
REQ-015 Accepted beats SHALL fill lanes in order, lane 0 (bits DATA_WIDTH-1:0) first.
REQ-016 A lane counter cnt (0..PACK-1) SHALL increment per accepted beat and wrap to 0 when a word is completed.
REQ-017 On acceptance of beat PACK-1, the word SHALL be moved to the output register, with out_valid=1 and out_keep all ones, one cycle later (1-cycle latency).
REQ-018 The output register SHALL hold out_data/out_keep stable while out_valid=1 and out_ready=0.
REQ-019 r_ready SHALL be 1 except when accepting a beat would complete or flush a word while out_valid=1 and out_ready=0; when r_ready is 0 for this reason, beats SHALL stall without loss.
REQ-020 Sustained throughput SHALL be one beat per clk cycle when out_ready is held at 1.
REQ-021 The state machine SHALL have states ACC (cnt=0 or partial), FLUSH_PEND (flush seen, output slot occupied) and DRAIN_WAIT (complete word blocked).
REQ-022 Flush with cnt>0 SHALL emit the partial word, with out_keep having ones in lanes 0..cnt-1 and zeros in the unused lanes and data, then reset cnt to 0.
REQ-023 Flush with cnt=0 and no beat accepted in the same cycle SHALL be a no-op.
REQ-024 Flush coincident with an accepted beat SHALL include that beat in the flushed word.
REQ-025 Flush arriving while the output slot is occupied SHALL move the machine to FLUSH_PEND, hold r_ready=0, and emit on the first cycle the slot frees.
REQ-026 Further flush pulses while in FLUSH_PEND SHALL be ignored.
REQ-027 Output word handoff (out_valid && out_ready) and loading a new word in the same cycle SHALL keep out_valid=1 with the new contents.

Reset
REQ-028 While rst_n=0, the module SHALL set out_valid=0, out_data=0, out_keep=0, busy=0, seq_err=0, r_ready=0, cnt=0, and state ACC.
REQ-029 The first cycle after rst_n deasserts, r_ready SHALL be 1.
REQ-030 Reset asserted mid-word SHALL discard partial data and any held output word.

Configuration
REQ-031 Macro FIFO_RD_PACKER_SEQCHK_EN SHALL compile in the sequence checker.
REQ-032 With FIFO_RD_PACKER_SEQCHK_EN defined, an expected-value counter (DATA_WIDTH bits, reset 0, wrapping modulo 2^DATA_WIDTH) SHALL be compared to each accepted r_data.
REQ-033 With the checker compiled in, a mismatch SHALL set seq_err=1 one cycle later until reset, and the expected value SHALL resync to r_data+1.
REQ-034 Without FIFO_RD_PACKER_SEQCHK_EN, the seq_err port SHALL remain present and be tied to 0.

Verification
REQ-035 PACK=4, out_ready=1, beats 0x00..0x07 back-to-back -> out_data 0x03020100 then 0x07060504, out_keep=4'hF, r_ready never 0.
REQ-036 Complete word held with out_ready=0 and beat 0x04..0x07 offered -> 0x04..0x06 accepted, r_ready=0 on 0x07 until out_ready=1, no beat lost.
REQ-037 Beats 0xA0,0xA1 then flush -> out_data 0x0000A1A0, out_keep=4'h3, cnt returns to 0.
REQ-038 Flush in the same cycle as beat 0xB2 after 0xB0,0xB1 -> out_keep=4'h7, out_data 0x00B2B1B0; flush at cnt=0 -> no output.
REQ-039 rst_n pulsed low after 2 beats -> all outputs 0, next beats 0x10..0x13 -> word 0x13121110.
REQ-040 SEQCHK_EN defined, beats 0x00,0x01,0x05,0x06 -> seq_err rises after 0x05 and stays 1; undefined -> seq_err stays 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Packs DATA_WIDTH beats from a FIFO read port into PACK-lane words.
// Optional sequence checker: define FIFO_RD_PACKER_SEQCHK_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       r_valid,
  input  logic [DATA_WIDTH-1:0]      r_data,
  output logic                       r_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       busy,
  output logic                       seq_err
);

  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WW = DATA_WIDTH * PACK;

  typedef enum logic [1:0] {
    ACC,
    FLUSH_PEND,
    DRAIN_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic [WW-1:0]   merged;
  logic [PACK-1:0] keep_m;
  logic            ov_q, ov_d;
  logic [WW-1:0]   od_q, od_d;
  logic [PACK-1:0] ok_q, ok_d;
  logic            blocked, last;
  logic            rdy, accept, load;

  always_comb begin
    blocked = ov_q && !out_ready;
    last    = (cnt_q == CW'(PACK - 1));
    unique case (state_q)
      ACC, DRAIN_WAIT: rdy = !(blocked && (last || flush));
      default:         rdy = 1'b0;
    endcase
    r_ready = rst_n && rdy;
    accept  = r_valid && r_ready;
  end

  // Current accumulator with the accepted beat (if any) in lane cnt.
  always_comb begin
    merged = acc_q;
    keep_m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (accept && CW'(i) == cnt_q)
        merged[i*DATA_WIDTH +: DATA_WIDTH] = r_data;
      keep_m[i] = (CW'(i) < cnt_q) || (accept && CW'(i) == cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ov_d    = ov_q && !out_ready;
    od_d    = od_q;
    ok_d    = ok_q;
    load    = 1'b0;
    unique case (state_q)
      ACC, DRAIN_WAIT: begin
        state_d = ACC;
        if (accept && (last || flush)) begin
          load = 1'b1;
        end else if (accept) begin
          acc_d = merged;
          cnt_d = cnt_q + CW'(1);
        end else if (flush && cnt_q != '0) begin
          if (blocked) state_d = FLUSH_PEND;
          else         load    = 1'b1;
        end else if (r_valid && last && blocked) begin
          state_d = DRAIN_WAIT;
        end
      end
      FLUSH_PEND: begin
        if (!blocked) begin
          load    = 1'b1;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    if (load) begin
      ov_d  = 1'b1;
      od_d  = merged;
      ok_d  = keep_m;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ok_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_keep  = ok_q;
  assign busy      = (cnt_q != '0) || (state_q == FLUSH_PEND) || ov_q;

`ifdef FIFO_RD_PACKER_SEQCHK_EN
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  err_q;

  // Resync to the received value on every beat, so a gap flags once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (r_data != exp_q) err_q <= 1'b1;
      exp_q <= r_data + 1'b1;
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer, DATA_WIDTH=8 PACK=4.
// Handed-off words are captured into a queue and compared to constants.
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic        r_valid;
  logic [7:0]  r_data;
  logic        r_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        busy;
  logic        seq_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic last_rdy;
  logic ok;
  logic [35:0] q[$];
  logic seq_exp;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_valid   (r_valid),
    .r_data    (r_data),
    .r_ready   (r_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .busy      (busy),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready)
      q.push_back({out_keep, out_data});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic fl);
    r_valid = 1'b1;
    r_data  = d;
    flush   = fl;
    #3;
    last_rdy = r_ready;
    tick();
    r_valid = 1'b0;
    flush   = 1'b0;
  endtask

  function automatic logic [35:0] qat(input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  initial begin
`ifdef FIFO_RD_PACKER_SEQCHK_EN
    seq_exp = 1'b1;
`else
    seq_exp = 1'b0;
`endif
    rst_n = 1'b0; r_valid = 1'b0; r_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_seq_err", seq_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #3 chk("rel_r_ready", r_ready, 1);

    // back-to-back, out_ready high
    tick();
    out_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(8'(i), 1'b0);
      ok &= last_rdy;
    end
    tick(); tick();
    chk("b2b_r_ready", ok, 1);
    chk("b2b_count", q.size(), 2);
    chk("b2b_w0", qat(0), 36'hF_03020100);
    chk("b2b_w1", qat(1), 36'hF_07060504);
    chk("b2b_busy", busy, 0);
    q.delete();

    // stall behind a held word
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'(i), 1'b0);
    ok = 1'b1;
    for (int i = 4; i < 7; i++) begin
      beat(8'(i), 1'b0);
      ok &= last_rdy;
    end
    chk("stall_acc_456", ok, 1);
    r_valid = 1'b1; r_data = 8'h07;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      ok &= !r_ready;
      ok &= out_valid && out_data == 32'h03020100 && out_keep == 4'hF;
      tick();
    end
    chk("stall_hold", ok, 1);
    out_ready = 1'b1;
    #3 chk("stall_release_rdy", r_ready, 1);
    tick();
    r_valid = 1'b0;
    #3;
    chk("swap_valid", out_valid, 1);
    chk("swap_data", out_data, 32'h07060504);
    tick();
    chk("stall_count", q.size(), 2);
    chk("stall_w0", qat(0), 36'hF_03020100);
    chk("stall_w1", qat(1), 36'hF_07060504);
    q.delete();

    // flush partial
    beat(8'hA0, 1'b0);
    beat(8'hA1, 1'b0);
    flush = 1'b1;
    #3 tick();
    flush = 1'b0;
    #3;
    chk("fl2_valid", out_valid, 1);
    chk("fl2_data", out_data, 32'h0000A1A0);
    chk("fl2_keep", out_keep, 4'h3);
    tick();
    #3 chk("fl2_busy", busy, 0);
    tick();

    // flush with coincident beat, then flush at cnt=0
    beat(8'hB0, 1'b0);
    beat(8'hB1, 1'b0);
    beat(8'hB2, 1'b1);
    #3;
    chk("fl3_keep", out_keep, 4'h7);
    chk("fl3_data", out_data, 32'h00B2B1B0);
    tick();
    flush = 1'b1;
    #3 tick();
    flush = 1'b0;
    #3 chk("fl0_noout_a", out_valid, 0);
    tick();
    #3 chk("fl0_noout_b", {out_valid, busy}, 0);
    q.delete();

    // flush while slot occupied
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'(8'h20 + i), 1'b0);
    beat(8'hC0, 1'b0);
    flush = 1'b1;
    #3 chk("fp_rdy_flush", r_ready, 0);
    tick();
    flush = 1'b0;
    #3;
    chk("fp_rdy_pend", r_ready, 0);
    chk("fp_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    #3 tick();
    #3;
    chk("fp_valid", out_valid, 1);
    chk("fp_data", out_data, 32'h000000C0);
    chk("fp_keep", out_keep, 4'h1);
    tick();
    #3;
    chk("fp_idle", {out_valid, busy}, 0);
    chk("fp_count", q.size(), 2);
    chk("fp_w0", qat(0), 36'hF_23222120);
    q.delete();

    // reset mid-word with a held output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'(8'h30 + i), 1'b0);
    beat(8'hEE, 1'b0);
    beat(8'hEF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_outs", {out_valid, out_data, out_keep, busy, r_ready, seq_err}, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #3 chk("mrst_rdy", r_ready, 1);
    tick();
    for (int i = 0; i < 4; i++) beat(8'(8'h10 + i), 1'b0);
    #3;
    chk("mrst_data", out_data, 32'h13121110);
    chk("mrst_keep", out_keep, 4'hF);
    tick();
    chk("mrst_count", q.size(), 1);
    q.delete();

    // sequence checker
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    beat(8'h00, 1'b0);
    beat(8'h01, 1'b0);
    #3 chk("seq_ok", seq_err, 0);
    beat(8'h05, 1'b0);
    #3 chk("seq_gap", seq_err, seq_exp);
    beat(8'h06, 1'b0);
    tick();
    #3 chk("seq_sticky", seq_err, seq_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
